seq_det_ctrl: RTL

Stream controller and detection counter for the 10101 serial sequence detector. It accepts parallel words over a valid/ready handshake and serializes them MSB-first, one bit per clock, into an internal pattern matcher. It reports each detection as a one-cycle pulse and keeps a saturating detection count for the FPGA top level: switches and buttons on the input side, LEDs and seven-segment display on the output side.

---
 rtl/seq_det_pkg.sv | 12 +
 rtl/seq_match.sv | 57 +++++
 rtl/seq_det_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the 10101 serial sequence detector.
package seq_det_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int                     DEF_PAT_LEN = 5;
    localparam logic [DEF_PAT_LEN-1:0] DEF_PATTERN = 5'b10101;

endpackage

// File: rtl/seq_match.sv
// Serial pattern matcher: rolling bit history, fill counter and a registered
// one-cycle detection pulse. History is never cleared on a match, so
// overlapping occurrences are all reported.
module seq_match
    import seq_det_pkg::*;
#(
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN
) (
    input  logic CLK,
    input  logic RST,
    input  logic bit_in,
    input  logic bit_en,
    input  logic flush,
    output logic detected
);

    localparam int                FILL_W    = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

    logic [PAT_LEN-1:0] hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               det_q, det_d;

    // Shift the new bit in and decide on a match against the updated history.
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        det_d  = 1'b0;
        if (flush) begin
            hist_d = '0;
            fill_d = '0;
        end else if (bit_en) begin
            hist_d = {hist_q[PAT_LEN-2:0], bit_in};
            if (fill_q != FILL_FULL) begin
                fill_d = fill_q + 1'b1;
            end
            det_d = (fill_d == FILL_FULL) && (hist_d == PATTERN);
        end
    end

    // History, fill and pulse registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hist_q <= '0;
            fill_q <= '0;
            det_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            det_q  <= det_d;
        end
    end

    assign detected = det_q;

endmodule

// File: rtl/seq_det_ctrl.sv
// Stream controller for the serial sequence detector: accepts words over
// valid/ready, serializes them MSB-first into seq_match and keeps a
// saturating detection count with a sticky overflow flag.
//
// Optional build macro SEQ_CTRL_FLUSH_EN: clears the matcher history after
// IDLE_FLUSH consecutive cycles without a serial bit.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | no word in flight, matcher not advancing
// SHIFT | word being shifted out, bit_idx = current bit (0..WORD_W-1)
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int                 WORD_W     = 8,
    parameter int                 CNT_W      = 8,
    parameter int                 PAT_LEN    = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN    = DEF_PATTERN,
    parameter int                 IDLE_FLUSH = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              enable,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              clear_cnt,
    output logic              code_out,
    output logic              bit_valid,
    output logic              detected,
    output logic [CNT_W-1:0]  det_count,
    output logic              overflow,
    output logic              busy
);

    localparam int               IDX_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   shift_q, shift_d;
    logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic                last_bit;
    logic                accept;
    logic                flush;

    assign last_bit  = (state_q == SHIFT) && (bit_idx_q == IDX_LAST);
    assign in_ready  = enable && ((state_q == IDLE) || last_bit);
    assign accept    = in_valid && in_ready;
    assign busy      = (state_q == SHIFT);
    assign bit_valid = busy;
    assign code_out  = busy && shift_q[WORD_W-1];

    // Next state for the serializer; a word accepted on the last bit reloads
    // without an idle cycle so back-to-back words stream gaplessly.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = SHIFT;
                    shift_d   = in_data;
                    bit_idx_d = '0;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    if (accept) begin
                        shift_d   = in_data;
                        bit_idx_d = '0;
                    end else begin
                        state_d   = IDLE;
                        shift_d   = '0;
                        bit_idx_d = '0;
                    end
                end else begin
                    shift_d   = {shift_q[WORD_W-2:0], 1'b0};
                    bit_idx_d = bit_idx_q + 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                shift_d   = '0;
                bit_idx_d = '0;
            end
        endcase
    end

    // Serializer state registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
        end
    end

    seq_match #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN)
    ) u_match (
        .CLK      (CLK),
        .RST      (RST),
        .bit_in   (code_out),
        .bit_en   (bit_valid),
        .flush    (flush),
        .detected (detected)
    );

    // cnt_q holds the committed count; the pulse in flight is folded in here
    // so det_count and overflow move in the same cycle detected is high.
    assign det_count = (detected && (cnt_q != CNT_MAX)) ? cnt_q + 1'b1 : cnt_q;
    assign overflow  = ovf_q || (detected && (cnt_q == CNT_MAX));

    // Commit the displayed count; a clear coinciding with a pulse keeps that one.
    always_comb begin
        cnt_d = det_count;
        ovf_d = overflow;
        if (clear_cnt) begin
            cnt_d = CNT_W'(detected);
            ovf_d = 1'b0;
        end
    end

    // Counter registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

`ifdef SEQ_CTRL_FLUSH_EN
    localparam int                IDLE_W    = $clog2(IDLE_FLUSH + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_FLUSH - 1);
    localparam logic [IDLE_W-1:0] IDLE_SAT  = IDLE_W'(IDLE_FLUSH);

    logic [IDLE_W-1:0] idle_q, idle_d;

    // Flush on the edge that ends the IDLE_FLUSH-th idle cycle, so a word
    // accepted on that same edge starts from an empty history.
    assign flush = !bit_valid && (idle_q == IDLE_LAST);

    // Count consecutive idle cycles, saturating once the flush threshold is hit.
    always_comb begin
        idle_d = idle_q;
        if (bit_valid) begin
            idle_d = '0;
        end else if (idle_q != IDLE_SAT) begin
            idle_d = idle_q + 1'b1;
        end
    end

    // Idle counter register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign flush = 1'b0;
`endif

endmodule
